argmax_stream: RTL and testbench
================================

# argmax_stream

Sequential classifier back end of the FC module: consumes the fully-connected layer's output scores one word per beat over a valid/ready stream, tracks the running maximum and its position, and presents the winning class index and score as a held result. It sits downstream of the FC accumulator and replaces a combinational comparator tree with a single compare per cycle. Comparison semantics match the team's existing comparator: unsigned magnitude compare.

## Interface
- WORD_SIZE, 16, width of one score word
- IDX_SIZE, 4, width of class index; NUM_CLASSES <= 2**IDX_SIZE required
- NUM_CLASSES, 10, scores per frame
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  score beat present
- in_ready  out  1  block can accept a beat
- in_data  in  WORD_SIZE  score, unsigned
- in_last  in  1  marks final score of the frame
- out_valid  out  1  result held and valid
- out_ready  in  1  consumer takes the result
- out_max  out  WORD_SIZE  winning score
- out_idx  out  IDX_SIZE  winning class index (0-based position in frame)
- out_err  out  1  frame length did not equal NUM_CLASSES

## Operation
- Two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
- Beat accepted when in_valid && in_ready.
- Internal: position counter cnt (IDX_SIZE bits), running run_max, run_idx.
- ACCUM, accepted beat with cnt==0: run_max<=in_data, run_idx<=0 unconditionally.
- ACCUM, accepted beat with cnt>0: if in_data > run_max (strict), run_max<=in_data, run_idx<=cnt; else unchanged. Ties keep the earlier (lower) index.
- cnt increments per accepted beat; no wrap inside a frame.
- Frame closes on the accepted beat where in_last==1 OR cnt==NUM_CLASSES-1, whichever first.
- On close: out_max/out_idx load the final winner (including the closing beat's compare), out_err<=(in_last==0 || cnt!=NUM_CLASSES-1), cnt<=0, state->HOLD.
- HOLD: out_valid=1; out_max/out_idx/out_err stable. On out_ready==1: state->ACCUM. in_valid ignored.
- out_max/out_idx/out_err keep their values after hand-off until the next frame closes.
- Beats beyond NUM_CLASSES without in_last begin a new frame (previous closed with out_err=1).

## Timing
- Reset (rst_n low, async): state=ACCUM, cnt=0, run_max=0, run_idx=0, out_max=0, out_idx=0, out_err=0, out_valid=0. in_ready=0 while rst_n low; 1 from the first clock after release.
- Throughput: one beat per cycle in ACCUM, no bubbles.
- Latency: out_valid rises the cycle after the closing beat is accepted.
- in_ready falls in that same cycle; at least one cycle of HOLD per frame.
- Handshake out_valid&&out_ready: in_ready=1 on the next cycle; a beat presented on that next cycle is cnt==0 of the new frame. No combinational path out_ready->in_ready.
- in_valid low mid-frame: state and counters hold.
- rst_n asserted mid-frame or in HOLD: partial frame and held result discarded, all outputs to reset values immediately.

## Test plan
- Scores 3,9,2,9,1,0,4,8,7,5 with in_last on beat 10 -> out_valid one cycle later, out_max=9, out_idx=1 (tie keeps first), out_err=0.
- All ten scores 0xFFFF -> out_max=0xFFFF, out_idx=0; all zeros -> out_max=0, out_idx=0, out_err=0.
- in_last on beat 4 (scores 1,2,8,3) -> out_max=8, out_idx=2, out_err=1; following full frame ends with out_err=0.
- Ten beats, no in_last, max 0x8000 at position 9 -> frame closes at beat 10, out_idx=9, out_err=1.
- out_ready held low 5 cycles with in_valid high -> in_ready=0, no beats accepted, outputs stable; out_ready pulse -> next beat lands at index 0.
- rst_n low mid-frame after 5 beats -> out_valid=0, out_max=0, out_idx=0 asynchronously; following full frame reports correct argmax.

Source files
------------

// File: rtl/argmax_stream.sv
// argmax_stream: streaming argmax over one frame of unsigned scores.
// Tracks running maximum and its position, one compare per accepted beat,
// and holds the winning score/index until the consumer takes it.
module argmax_stream #(
  parameter int unsigned WORD_SIZE   = 16,
  parameter int unsigned IDX_SIZE    = 4,
  parameter int unsigned NUM_CLASSES = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_max,
  output logic [IDX_SIZE-1:0]  out_idx,
  output logic                 out_err
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [IDX_SIZE-1:0] LAST_CNT = IDX_SIZE'(NUM_CLASSES - 1);

  state_t               state;
  logic [IDX_SIZE-1:0]  cnt;
  logic [WORD_SIZE-1:0] run_max;
  logic [IDX_SIZE-1:0]  run_idx;

  logic                 accept_c;
  logic                 close_c;
  logic                 err_c;
  logic [WORD_SIZE-1:0] win_max_c;
  logic [IDX_SIZE-1:0]  win_idx_c;

  // Winner after folding in the current beat; the first beat seeds the
  // running pair, later beats replace it only on a strictly larger score.
  always_comb begin
    accept_c  = in_valid && in_ready;
    win_max_c = run_max;
    win_idx_c = run_idx;
    if (cnt == '0) begin
      win_max_c = in_data;
      win_idx_c = '0;
    end else if (in_data > run_max) begin
      win_max_c = in_data;
      win_idx_c = cnt;
    end
    close_c = accept_c && (in_last || (cnt == LAST_CNT));
    err_c   = !in_last || (cnt != LAST_CNT);
  end

  // Frame FSM with registered handshake outputs; in_ready is driven from
  // state only, so out_ready never reaches it combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      cnt       <= '0;
      run_max   <= '0;
      run_idx   <= '0;
      out_max   <= '0;
      out_idx   <= '0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          in_ready <= 1'b1;
          if (accept_c) begin
            run_max <= win_max_c;
            run_idx <= win_idx_c;
            if (close_c) begin
              out_max   <= win_max_c;
              out_idx   <= win_idx_c;
              out_err   <= err_c;
              cnt       <= '0;
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              cnt <= cnt + IDX_SIZE'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= ACCUM;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ACCUM;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_argmax_stream.sv
// Directed bench for argmax_stream with hand-computed expected results.
module tb_argmax_stream;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_max;
  logic [3:0]  out_idx;
  logic        out_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] fr [10];

  argmax_stream #(
    .WORD_SIZE  (16),
    .IDX_SIZE   (4),
    .NUM_CLASSES(10)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_max  (out_max),
    .out_idx  (out_idx),
    .out_err  (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Compare one observed value against its expectation and tally it.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one beat (called at a negedge) and return at the negedge after acceptance.
  task automatic beat(input logic [15:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check_eq("ready_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Stream len scores from fr, optionally with idle cycles after beat gap_at.
  task automatic run_frame(input int len, input logic use_last, input int gap_at);
    for (int i = 0; i < len; i++) begin
      beat(fr[i], use_last && (i == len - 1));
      if (i == gap_at) repeat (3) @(negedge clk);
    end
  endtask

  // Result must be presented one cycle after the closing beat.
  task automatic check_result(input string tag, input logic [15:0] m, input logic [3:0] idx,
                              input logic err);
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_ready"}, 32'(in_ready), 32'd0);
    check_eq({tag, "_max"}, 32'(out_max), 32'(m));
    check_eq({tag, "_idx"}, 32'(out_idx), 32'(idx));
    check_eq({tag, "_err"}, 32'(out_err), 32'(err));
  endtask

  // One-cycle out_ready pulse; result must persist after hand-off.
  task automatic handoff(input string tag, input logic [15:0] m);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, "_ho_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_ho_ready"}, 32'(in_ready), 32'd1);
    check_eq({tag, "_ho_max"}, 32'(out_max), 32'(m));
  endtask

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_ready", 32'(in_ready), 32'd0);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_max", 32'(out_max), 32'd0);
    check_eq("rst_idx", 32'(out_idx), 32'd0);
    check_eq("rst_err", 32'(out_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_ready", 32'(in_ready), 32'd1);

    // Tie keeps earliest index; idle gap mid-frame must not disturb counting.
    fr = '{16'd3, 16'd9, 16'd2, 16'd9, 16'd1, 16'd0, 16'd4, 16'd8, 16'd7, 16'd5};
    run_frame(10, 1'b1, 3);
    check_result("tie", 16'd9, 4'd1, 1'b0);
    handoff("tie", 16'd9);

    fr = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
           16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    run_frame(10, 1'b1, -1);
    check_result("all_ff", 16'hFFFF, 4'd0, 1'b0);
    handoff("all_ff", 16'hFFFF);

    fr = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    run_frame(10, 1'b1, -1);
    check_result("all_zero", 16'd0, 4'd0, 1'b0);
    handoff("all_zero", 16'd0);

    // Early in_last: short frame flagged, next full frame clean.
    fr = '{16'd1, 16'd2, 16'd8, 16'd3, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    run_frame(4, 1'b1, -1);
    check_result("short", 16'd8, 4'd2, 1'b1);
    handoff("short", 16'd8);

    fr = '{16'd5, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd6};
    run_frame(10, 1'b1, -1);
    check_result("after_short", 16'd6, 4'd9, 1'b0);
    handoff("after_short", 16'd6);

    // Missing in_last: frame closes on beat 10 with error.
    fr = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'h8000};
    run_frame(10, 1'b0, -1);
    check_result("no_last", 16'h8000, 4'd9, 1'b1);

    // Stall in HOLD with a large score offered; nothing may be accepted.
    in_valid = 1'b1;
    in_data  = 16'hAAAA;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("stall_ready", 32'(in_ready), 32'd0);
      check_eq("stall_valid", 32'(out_valid), 32'd1);
      check_eq("stall_max", 32'(out_max), 32'h8000);
      check_eq("stall_idx", 32'(out_idx), 32'd9);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("stall_ho_ready", 32'(in_ready), 32'd1);
    // First beat right after hand-off must land at index 0.
    fr = '{16'd7, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd0, 16'd0, 16'd0};
    run_frame(10, 1'b1, -1);
    check_result("after_stall", 16'd7, 4'd0, 1'b0);
    handoff("after_stall", 16'd7);

    // Asynchronous reset mid-frame discards partial frame and held result.
    fr = '{16'h100, 16'h200, 16'h300, 16'h400, 16'h500, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    run_frame(5, 1'b0, -1);
    #3 rst_n = 1'b0;
    #1;
    check_eq("arst_valid", 32'(out_valid), 32'd0);
    check_eq("arst_max", 32'(out_max), 32'd0);
    check_eq("arst_idx", 32'(out_idx), 32'd0);
    check_eq("arst_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fr = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd2};
    run_frame(10, 1'b1, -1);
    check_result("after_arst", 16'd9, 4'd8, 1'b0);
    handoff("after_arst", 16'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
